// File: rtl/pipelined_adder.sv
// Chunk-pipelined n-bit add/subtract: one k-bit ripple chunk per stage, with a
// valid/ready handshake where a single enable freezes the whole pipeline.
module pipelined_adder #(
  parameter int n = 32,
  parameter int k = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] num1,
  input  logic [n-1:0] num2,
  input  logic         carry_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] sum,
  output logic         carry,
  output logic         overflow
);

  localparam int STAGES = n / k;
  localparam int LAST   = STAGES - 1;

  // Per-stage registers: operands (B already conditionally inverted),
  // partial sum, chunk carry, mode bit and valid bit.
  logic [n-1:0] a_r   [STAGES];
  logic [n-1:0] b_r   [STAGES];
  logic [n-1:0] s_r   [STAGES];
  logic         c_r   [STAGES];
  logic         sub_r [STAGES];
  logic         v_r   [STAGES];
  logic         carry_r;
  logic         ovf_r;

  // Values presented to each stage and the results it will register.
  logic [n-1:0] src_a_s   [STAGES];
  logic [n-1:0] src_b_s   [STAGES];
  logic [n-1:0] src_s_s   [STAGES];
  logic         src_c_s   [STAGES];
  logic         src_sub_s [STAGES];
  logic         src_v_s   [STAGES];
  logic [k:0]   chunk_s   [STAGES];
  logic [n-1:0] nsum_s    [STAGES];
  logic         en_s;

  assign en_s      = !v_r[LAST] || out_ready;
  assign in_ready  = en_s;
  assign out_valid = v_r[LAST];
  assign sum       = s_r[LAST];
  assign carry     = carry_r;
  assign overflow  = ovf_r;

  // Route stage inputs and ripple-add the chunk each stage owns.
  always_comb begin
    src_a_s[0]   = num1;
    src_b_s[0]   = sub ? ~num2 : num2;
    src_s_s[0]   = {n{1'b0}};
    src_c_s[0]   = carry_in ^ sub;
    src_sub_s[0] = sub;
    src_v_s[0]   = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      src_a_s[i]   = a_r[i-1];
      src_b_s[i]   = b_r[i-1];
      src_s_s[i]   = s_r[i-1];
      src_c_s[i]   = c_r[i-1];
      src_sub_s[i] = sub_r[i-1];
      src_v_s[i]   = v_r[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      chunk_s[i] = {1'b0, src_a_s[i][i*k +: k]} + {1'b0, src_b_s[i][i*k +: k]}
                 + {{k{1'b0}}, src_c_s[i]};
      nsum_s[i]  = src_s_s[i];
      nsum_s[i][i*k +: k] = chunk_s[i][k-1:0];
    end
  end

  // Advance every stage together, bubbles included, whenever the output slot frees up.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        a_r[i]   <= {n{1'b0}};
        b_r[i]   <= {n{1'b0}};
        s_r[i]   <= {n{1'b0}};
        c_r[i]   <= 1'b0;
        sub_r[i] <= 1'b0;
        v_r[i]   <= 1'b0;
      end
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (en_s) begin
      for (int i = 0; i < STAGES; i++) begin
        a_r[i]   <= src_a_s[i];
        b_r[i]   <= src_b_s[i];
        s_r[i]   <= nsum_s[i];
        c_r[i]   <= chunk_s[i][k];
        sub_r[i] <= src_sub_s[i];
        v_r[i]   <= src_v_s[i];
      end
      carry_r <= chunk_s[LAST][k] ^ src_sub_s[LAST];
      ovf_r   <= (src_a_s[LAST][n-1] == src_b_s[LAST][n-1]) &&
                 (nsum_s[LAST][n-1] != src_a_s[LAST][n-1]);
    end
  end

endmodule
